// File: rtl/truth_table_sweeper.sv
// Sweeps all eight input combinations of a 3-input gate, samples its output after a
// programmable settle time, and compares the assembled truth table to an expected value.
module truth_table_sweeper #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] expected,
    output logic       dut_in1,
    output logic       dut_in2,
    output logic       dut_in3,
    input  logic       dut_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] truth_table,
    output logic       match
);

    typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

    localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] k_q, k_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] shadow_q, shadow_d;
    logic [7:0] exp_q, exp_d;
    logic [7:0] tt_q, tt_d;
    logic       match_q, match_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [2:0] dut_in_q, dut_in_d;
    logic [7:0] full;

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        exp_d    = exp_q;
        tt_d     = tt_q;
        match_d  = match_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        dut_in_d = '0;
        // Row k lands in bit (7-k) so row 000 is the MSB of the hex gate name.
        full = shadow_q;
        full[3'd7 - k_q] = dut_out;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SETTLE;
                    exp_d    = expected;
                    k_d      = '0;
                    cnt_d    = RELOAD;
                    shadow_d = '0;
                    busy_d   = 1'b1;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    shadow_d = full;
                    if (k_q != 3'd7) begin
                        k_d      = k_q + 3'd1;
                        cnt_d    = RELOAD;
                        busy_d   = 1'b1;
                        dut_in_d = k_q + 3'd1;
                    end else begin
                        state_d = DONE;
                        tt_d    = full;
                        match_d = (full == exp_q);
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d    = cnt_q - 8'd1;
                    busy_d   = 1'b1;
                    dut_in_d = k_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            k_q      <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            exp_q    <= '0;
            tt_q     <= '0;
            match_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dut_in_q <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            exp_q    <= exp_d;
            tt_q     <= tt_d;
            match_q  <= match_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dut_in_q <= dut_in_d;
        end
    end

    assign dut_in1     = dut_in_q[2];
    assign dut_in2     = dut_in_q[1];
    assign dut_in3     = dut_in_q[0];
    assign busy        = busy_q;
    assign done        = done_q;
    assign truth_table = tt_q;
    assign match       = match_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Checks truth_table_sweeper against a cycle-arithmetic reference model with random gates,
// aborts, held start, mid-sweep reset, and delayed-gate sweeps at short settle times.
module tb_truth_table_sweeper;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] expected = '0;
    logic [7:0] gate_tt = '0;
    logic       in1, in2, in3, dut_out, busy, done, match;
    logic [7:0] truth_table;

    always #5 clk = ~clk;

    assign dut_out = gate_tt[3'd7 - {in1, in2, in3}];

    truth_table_sweeper #(.SETTLE_CYCLES(S)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected(expected),
        .dut_in1(in1), .dut_in2(in2), .dut_in3(in3), .dut_out(dut_out),
        .busy(busy), .done(done), .truth_table(truth_table), .match(match)
    );

    // Short-settle instances driving a registered (one-cycle-late) XOR3 gate.
    logic       start_f = 1'b0;
    logic       abort_f = 1'b0;
    logic [7:0] exp_f = 8'h69;
    logic       a_in1, a_in2, a_in3, a_busy, a_done, a_match;
    logic       b_in1, b_in2, b_in3, b_busy, b_done, b_match;
    logic [7:0] a_tt, b_tt;
    logic       a_out = 1'b0;
    logic       b_out = 1'b0;

    always @(posedge clk) begin
        a_out <= a_in1 ^ a_in2 ^ a_in3;
        b_out <= b_in1 ^ b_in2 ^ b_in3;
    end

    truth_table_sweeper #(.SETTLE_CYCLES(1)) u_fast1 (
        .clk(clk), .rst_n(rst_n), .start(start_f), .abort(abort_f), .expected(exp_f),
        .dut_in1(a_in1), .dut_in2(a_in2), .dut_in3(a_in3), .dut_out(a_out),
        .busy(a_busy), .done(a_done), .truth_table(a_tt), .match(a_match)
    );

    truth_table_sweeper #(.SETTLE_CYCLES(2)) u_fast2 (
        .clk(clk), .rst_n(rst_n), .start(start_f), .abort(abort_f), .expected(exp_f),
        .dut_in1(b_in1), .dut_in2(b_in2), .dut_in3(b_in3), .dut_out(b_out),
        .busy(b_busy), .done(b_done), .truth_table(b_tt), .match(b_match)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] m_tt = '0;
    logic       m_match = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One sweep: cycle c (1..8S+1) counts from the edge that accepts start.
    task automatic sweep(input logic [7:0] g, input logic [7:0] e, input int abort_at, input bit hold);
        bit aborted = 1'b0;
        bit live;
        gate_tt  = g;
        expected = e;
        start    = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        expected = 8'($urandom);
        for (int c = 1; c <= 8 * S + 1; c++) begin
            live = !aborted && c <= 8 * S;
            if (!aborted && c == 8 * S + 1) begin
                m_tt    = g;
                m_match = (g == e);
            end
            chk("busy", 32'(busy), 32'(live));
            chk("done", 32'(done), 32'(!aborted && c == 8 * S + 1));
            chk("dut_in", 32'({in1, in2, in3}), live ? 32'((c - 1) / S) : 32'd0);
            chk("truth_table", 32'(truth_table), 32'(m_tt));
            chk("match", 32'(match), 32'(m_match));
            abort = (c == abort_at);
            if (c == abort_at) aborted = 1'b1;
            if (abort_at < 0 && c == 8 * S + 1) abort = 1'($urandom_range(0, 1));
            if (!hold) start = (abort_at < 0 && c <= 8 * S) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk); #1;
        end
        abort = 1'b0;
    endtask

    initial begin
        logic [7:0] g;
        logic [7:0] art;
        logic [2:0] prev;
        int         d1, d2;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_tt", 32'(truth_table), 32'd0);
        chk("rst_match", 32'(match), 32'd0);
        chk("rst_dut_in", 32'({in1, in2, in3}), 32'd0);
        rst_n = 1'b1;

        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("idle_abort_busy", 32'(busy), 32'd0);

        sweep(8'h40, 8'h40, -1, 1'b0);
        sweep(8'h01, 8'h40, -1, 1'b0);
        sweep(8'h40, 8'h40, -1, 1'b0);
        sweep(8'h7F, 8'h7F, 10, 1'b0);
        sweep(8'h7F, 8'h7F, 8, 1'b0);
        sweep(8'h96, 8'h96, 8 * S, 1'b0);

        for (int i = 0; i < 6; i++) begin
            g = 8'($urandom);
            sweep(g, ($urandom_range(0, 1) != 0) ? g : 8'($urandom), -1, 1'b0);
        end

        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            g = 8'($urandom);
            sweep(g, (i == 1) ? ~g : g, -1, 1'b1);
        end
        start = 1'b0;
        @(posedge clk); #1;
        chk("hold_release_busy", 32'(busy), 32'd0);

        gate_tt  = 8'h96;
        expected = 8'h96;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        m_tt    = '0;
        m_match = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_dut_in", 32'({in1, in2, in3}), 32'd0);
        chk("midrst_tt", 32'(truth_table), 32'd0);
        chk("midrst_match", 32'(match), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        sweep(8'h40, 8'h40, -1, 1'b0);

        // Delayed gate: the sample for row k sees the inputs of the previous cycle.
        art = '0;
        for (int k = 0; k < 8; k++) begin
            prev = (k == 0) ? 3'd0 : 3'(k - 1);
            art[7 - k] = ^prev;
        end
        d1 = -1;
        d2 = -1;
        start_f = 1'b1;
        @(posedge clk); #1;
        start_f = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (a_done && d1 < 0) d1 = c;
            if (b_done && d2 < 0) d2 = c;
            @(posedge clk); #1;
        end
        chk("s1_done_cycle", 32'(d1), 32'd9);
        chk("s2_done_cycle", 32'(d2), 32'd17);
        chk("s1_tt", 32'(a_tt), 32'(art));
        chk("s1_match", 32'(a_match), 32'(art == 8'h69));
        chk("s2_tt", 32'(b_tt), 32'h69);
        chk("s2_match", 32'(b_match), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
